// File: rtl/boot_loader.sv
// boot_loader: streams a counted little-endian word image into instruction memory,
// then releases the core from reset after a fixed delay.
module boot_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 512,
    parameter int RST_DELAY = 20
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              wen_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              core_rstn_o,
    output logic              done_o,
    output logic              err_o
);
    typedef enum logic [2:0] {HDR_LO, HDR_HI, LOAD, WRITE, WAIT, DONE, ERR} state_t;
    state_t            state, state_n;
    logic [15:0]       count, count_full;
    logic [31:0]       word, instr_q;
    logic [1:0]        k;
    logic [ADDR_W-3:0] word_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dly;
    logic              xfer, last, hdr_bad;
    always_comb begin
        byte_ready_o = reset_i && (state == HDR_LO || state == HDR_HI || state == LOAD);
        xfer         = byte_valid_i && byte_ready_o;
        count_full   = {byte_i, count[7:0]};
        hdr_bad      = count_full == 16'd0 || count_full > 16'(MAX_WORDS);
        last         = 16'(word_idx) + 16'd1 == count;
        wen_o        = state != WRITE;
        // Outside WRITE the memory port shows the last word actually written
        instr_o      = wen_o ? instr_q : word;
        addr_o       = wen_o ? addr_q : {word_idx, 2'b00};
        core_rstn_o  = state == DONE;
        done_o       = state == DONE;
        err_o        = state == ERR;
        state_n      = state;
        case (state)
            HDR_LO:  state_n = xfer ? HDR_HI : HDR_LO;
            HDR_HI:  state_n = xfer ? (hdr_bad ? ERR : LOAD) : HDR_HI;
            LOAD:    state_n = (xfer && k == 2'd3) ? WRITE : LOAD;
            WRITE:   state_n = last ? WAIT : LOAD;
            WAIT:    state_n = dly == 8'(RST_DELAY - 1) ? DONE : WAIT;
            DONE:    state_n = DONE;
            default: state_n = ERR;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state    <= HDR_LO;
            count    <= '0;
            word     <= '0;
            k        <= '0;
            word_idx <= '0;
            dly      <= '0;
            instr_q  <= '0;
            addr_q   <= '0;
        end else begin
            state <= state_n;
            if (xfer && state == HDR_LO) count[7:0] <= byte_i;
            if (xfer && state == HDR_HI) count[15:8] <= byte_i;
            if (xfer && state == LOAD) begin
                word[{k, 3'b000} +: 8] <= byte_i;
                k                      <= k + 2'd1;
            end
            if (state == WRITE) begin
                instr_q  <= word;
                addr_q   <= {word_idx, 2'b00};
                word_idx <= word_idx + 1'b1;
            end
            dly <= state == WAIT ? dly + 8'd1 : 8'd0;
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: header table, scoreboarded write checks, release timing and reset corners.
module tb_boot_loader;
    logic        clk_i = 0, reset_i = 0, byte_valid_i = 0;
    logic [7:0]  byte_i = 0;
    logic        byte_ready_o, wen_o, core_rstn_o, done_o, err_o;
    logic [31:0] instr_o;
    logic [10:0] addr_o;

    boot_loader dut (
        .clk_i(clk_i), .reset_i(reset_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o), .wen_o(wen_o), .instr_o(instr_o), .addr_o(addr_o),
        .core_rstn_o(core_rstn_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int          compared = 0, mismatched = 0, cyc = 0, last_wr = 0;
    bit          chk_rdy = 0;
    logic [42:0] exp_q[$];
    logic [31:0] prog[$];

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       err;
    } hdr_t;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        logic [42:0] e;
        if (reset_i && chk_rdy) chk("ready_vs_write", {31'b0, byte_ready_o}, {31'b0, wen_o});
        if (wen_o === 1'b0) begin
            last_wr = cyc;
            chk("core_rstn_during_write", {31'b0, core_rstn_o}, 32'd0);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: addr %h data %h expected no write", addr_o, instr_o);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {21'b0, addr_o}, {21'b0, e[42:32]});
                chk("write_data", instr_o, e[31:0]);
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit keep);
        int t = 0;
        byte_i = b;
        byte_valid_i = 1;
        @(negedge clk_i);
        while (!byte_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (!byte_ready_o) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: ready got 0 expected 1");
        end
        @(posedge clk_i);
        #1;
        if (!keep) byte_valid_i = 0;
    endtask

    task automatic gap(input bit g);
        int n;
        if (g) begin
            n = $urandom_range(0, 5);
            repeat (n) begin
                @(posedge clk_i);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        byte_valid_i = 0;
        reset_i = 0;
        @(posedge clk_i);
        #1;
        reset_i = 1;
    endtask

    task automatic load(input logic [15:0] n, input bit gaps);
        logic [31:0] w;
        chk_rdy = !gaps;
        send(n[7:0], !gaps);
        gap(gaps);
        send(n[15:8], !gaps);
        gap(gaps);
        for (int i = 0; i < int'(n); i++) begin
            w = prog[i];
            exp_q.push_back({11'(i * 4), w});
            for (int j = 0; j < 4; j++) begin
                send(w[8*j +: 8], !gaps);
                gap(gaps);
            end
        end
        chk_rdy = 0;
        byte_valid_i = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done_o && t < 400) begin
            @(negedge clk_i);
            t++;
        end
        chk("done_seen", {31'b0, done_o}, 32'd1);
        chk("release_delay", 32'(cyc - last_wr), 32'd21);
        chk("core_rstn_released", {31'b0, core_rstn_o}, 32'd1);
        chk("err_clear", {31'b0, err_o}, 32'd0);
    endtask

    initial begin
        hdr_t ht[6];
        int   seen;
        ht = '{'{8'h00, 8'h00, 1'b1}, '{8'h01, 8'h02, 1'b1}, '{8'h00, 8'h02, 1'b0},
               '{8'hFF, 8'hFF, 1'b1}, '{8'h01, 8'h00, 1'b0}, '{8'hFF, 8'h01, 1'b0}};

        reset_i = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_wen", {31'b0, wen_o}, 32'd1);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_addr", {21'b0, addr_o}, 32'd0);
        chk("rst_core_rstn", {31'b0, core_rstn_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_ready", {31'b0, byte_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        reset_i = 1;
        @(negedge clk_i);
        chk("ready_after_rst", {31'b0, byte_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;

        foreach (ht[i]) begin
            do_reset();
            send(ht[i].lo, 0);
            send(ht[i].hi, 0);
            @(negedge clk_i);
            chk("hdr_err", {31'b0, err_o}, {31'b0, ht[i].err});
            chk("hdr_ready", {31'b0, byte_ready_o}, {31'b0, !ht[i].err});
            chk("hdr_core_rstn", {31'b0, core_rstn_o}, 32'd0);
            if (ht[i].err) begin
                byte_i = 8'h13;
                byte_valid_i = 1;
                repeat (10) @(negedge clk_i);
                chk("err_sticky", {31'b0, err_o}, 32'd1);
                chk("err_core_rstn", {31'b0, core_rstn_o}, 32'd0);
            end
            @(posedge clk_i);
            #1;
        end

        prog = '{32'h2A000113, 32'h00010433, 32'h0F80006F};
        do_reset();
        load(16'd3, 0);
        wait_done();
        byte_i = 8'h55;
        byte_valid_i = 1;
        repeat (50) begin
            @(negedge clk_i);
            chk("post_done_ready", {31'b0, byte_ready_o}, 32'd0);
            chk("post_done_done", {31'b0, done_o}, 32'd1);
            chk("post_done_rstn", {31'b0, core_rstn_o}, 32'd1);
        end
        @(posedge clk_i);
        #1;

        do_reset();
        load(16'd3, 1);
        wait_done();

        prog.delete();
        for (int i = 0; i < 512; i++) prog.push_back(32'(i));
        do_reset();
        load(16'h0200, 0);
        wait_done();

        do_reset();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        do_reset();
        prog = '{32'h12345678};
        load(16'd1, 0);
        wait_done();

        do_reset();
        prog = '{32'hCAFEF00D};
        load(16'd1, 0);
        repeat (5) @(negedge clk_i);
        chk("wait_not_done", {31'b0, done_o}, 32'd0);
        do_reset();
        @(negedge clk_i);
        chk("wait_rst_core_rstn", {31'b0, core_rstn_o}, 32'd0);
        chk("wait_rst_hdr_lo_ready", {31'b0, byte_ready_o}, 32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (done_o || core_rstn_o) seen++;
        end
        chk("no_release_after_wait_reset", 32'(seen), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream feeder for the RISC-V core top level. Drives the core's instruction-memory write port (active-low write enable, 32-bit word, 11-bit byte address) and the core's active-low reset.
- Accepts a byte stream (valid/ready), parses a 2-byte word-count header and assembles little-endian 32-bit words.
- Writes each word to consecutive word addresses from 0.
- After the last write, holds the core in reset for a fixed delay, then releases it.

Parameters:
- ADDR_W, 11, byte-address width of the instruction memory port.
- MAX_WORDS, 512, largest legal word count; equals 2^(ADDR_W-2).
- RST_DELAY, 20, clk_i cycles between the last write and core reset release; legal range 1..255.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-low reset.
- byte_i  input  8  stream data byte.
- byte_valid_i  input  1  byte_i valid this cycle.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- wen_o  output  1  instruction-memory write enable, active-low; 0 = write this cycle.
- instr_o  output  32  instruction-memory write data.
- addr_o  output  ADDR_W  instruction-memory byte address, always word-aligned.
- core_rstn_o  output  1  core reset, active-low; 0 holds the core in reset.
- done_o  output  1  load complete and core released.
- err_o  output  1  illegal header; sticky until reset.

Behaviour:
- Byte transfer occurs on a rising edge with byte_valid_i=1 and byte_ready_o=1. byte_ready_o is combinational from state, and is 0 whenever reset_i=0.
- Reset (reset_i=0 at an edge), from any state including mid-word or mid-delay:
  - state goes to HDR_LO; word index, byte index and delay counter go to 0.
  - wen_o=1, instr_o=0, addr_o=0, core_rstn_o=0, done_o=0, err_o=0.
  - any partial word is discarded.
- State machine:
  - HDR_LO: ready=1. On transfer, capture count[7:0] and go to HDR_HI.
  - HDR_HI: ready=1. On transfer, capture count[15:8]. If the full count is 0 or > MAX_WORDS, go to ERR; otherwise go to LOAD.
  - LOAD: ready=1. Byte k (k=0..3) is placed in word[8k+7:8k], then k increments. On the 4th transfer go to WRITE.
  - WRITE: exactly one cycle.
    - ready=0, wen_o=0, instr_o=assembled word, addr_o={word_idx,2'b00}.
    - word_idx increments at the end of the cycle.
    - If word_idx+1 == count, go to WAIT with the delay counter cleared; otherwise go to LOAD with k=0.
  - WAIT: ready=0, wen_o=1. The counter increments each cycle; when it reaches RST_DELAY-1, go to DONE.
  - DONE: ready=0, core_rstn_o=1, done_o=1. Terminal until reset.
  - ERR: ready=0, err_o=1, core_rstn_o=0. No writes. Terminal until reset.
- Timing:
  - core_rstn_o rises exactly RST_DELAY+1 cycles after the WRITE cycle of the last word.
  - Back-to-back bytes give 5 cycles per word: 4 accept cycles plus 1 WRITE bubble.
- Outputs outside WRITE: wen_o=1. instr_o and addr_o hold their last written values; bench must not check them while wen_o=1.
- Width rules:
  - word_idx is ADDR_W-2 bits wide; count is 16 bits.
  - The count comparison is done at 16 bits, so 0x0200 is legal and 0x0201 is an error.
  - Last legal address is 0x7FC; there is no wrap.
- Bytes offered in WAIT, DONE or ERR are not accepted and have no effect.

Test Plan:
- Normal load:
  - Stimulus: 03 00 | 13 01 00 2A | 33 04 01 00 | 6F 00 80 0F.
  - Required: three single-cycle wen_o=0 writes: addr 0 / 0x2A000113, addr 4 / 0x00010433, addr 8 / 0x0F80006F.
  - core_rstn_o=0 throughout loading; core_rstn_o and done_o go to 1 exactly 21 cycles after the third write.
- Streaming and gaps:
  - byte_valid_i held high continuously: byte_ready_o drops only during WRITE cycles; no byte lost or duplicated; written data matches the scenario above.
  - Random 0-5 cycle valid gaps: identical writes.
- Bad header:
  - 00 00 → err_o=1 the cycle after the second byte, byte_ready_o=0, no wen_o pulse, core_rstn_o stays 0.
  - 01 02 (513 words) → same response.
- Maximum size:
  - Header 00 02 plus 512 words with value = index → 512 writes.
  - Last write at addr 0x7FC with data 0x000001FF; then done_o=1.
- Reset mid-operation:
  - Header 02 00, then 2 bytes of word 0, then reset_i=0 for one cycle.
  - Then 01 00 | 78 56 34 12 → single write at addr 0 with data 0x12345678 (no stale bytes), and done_o follows.
  - Repeat with reset asserted during WAIT: core_rstn_o stays 0 and the loader returns to HDR_LO.
- Post-done:
  - After DONE, byte_valid_i=1 for 50 cycles → byte_ready_o=0, no writes, core_rstn_o and done_o remain 1.
